mrd_stage_seq: RTL and testbench
================================

# mrd_stage_seq

Stage sequencer for the mixed-radix DFT memory subsystem. Accepts a packet configuration (DFT size and radix factor list), precomputes per-stage stride/span parameters by sequential multiplication, validates them, then sequences the radix stages and the final source (read-out) phase through start/done handshakes. It sits between the packet-level control interface and the memory top, replacing ad-hoc per-stage parameter latching with one checked schedule.

## Interface
Parameters:
- wPTS, 12, width of DFT point count and of stride/span outputs
- MAXF, 6, maximum number of radix factors (stages)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to schedule a new packet; accepted only in IDLE
- dftpts  in  wPTS  DFT size, sampled with start
- num_factors  in  3  number of stages N, sampled with start; legal 1..MAXF
- nf  in  MAXF×3  radix factors nf[0..5], sampled with start; legal values 2,3,4,5
- stage_done  in  1  one-cycle pulse: current stage's read and write-back complete
- source_done  in  1  one-cycle pulse: output read-out complete
- busy  out  1  high in any state except IDLE
- stage_start  out  1  one-cycle pulse launching a radix stage
- stage_idx  out  3  index of current stage
- stage_nf  out  3  radix of current stage
- stage_stride  out  wPTS  product nf[k+1..N-1] (1 for last stage)
- stage_span  out  wPTS  product nf[k..N-1] (twiddle denominator)
- last_stage  out  1  current stage is N-1
- source_start  out  1  one-cycle pulse launching read-out
- pkt_done  out  1  one-cycle pulse at packet completion
- err  out  1  one-cycle pulse on rejected configuration
- err_code  out  2  0 none, 1 product≠dftpts or overflow, 2 illegal factor, 3 illegal N; held until next accepted start

## Operation
- States: IDLE, CALC, CHECK, STAGE_GO, STAGE_WAIT, SRC_GO, SRC_WAIT, ERR.
- IDLE: on start, latch dftpts/num_factors/nf, clear err_code, acc←1, j←N-1; go CALC if 1≤N≤MAXF, else CHECK directly.
- CALC: one factor per cycle, j descending: stride[j]←acc; span[j]←acc×nf[j]; acc←acc×nf[j]. Products computed ≥16 bits wide; any intermediate >2^wPTS−1 sets overflow flag. Exits to CHECK after j=0 (N cycles).
- CHECK: priority error code 3 (N illegal), then 2 (any nf[0..N-1] ∉ {2,3,4,5}), then 1 (overflow or acc≠dftpts). Error → ERR; else k←0, STAGE_GO.
- STAGE_GO: pulse stage_start; load stage_idx=k, stage_nf=nf[k], stride[k], span[k], last_stage=(k==N−1). → STAGE_WAIT.
- STAGE_WAIT: on stage_done: last stage → SRC_GO, else k←k+1, STAGE_GO.
- SRC_GO: pulse source_start → SRC_WAIT. SRC_WAIT: on source_done → IDLE with pkt_done pulse.
- ERR: pulse err, → IDLE.
- Stage outputs hold their values between STAGE_GO loads and after completion, until next load or reset.
- start outside IDLE ignored. stage_done outside STAGE_WAIT, source_done outside SRC_WAIT ignored. Factors nf[N..5] are don't-care.

## Timing
- Reset: all outputs 0, state IDLE, internal tables cleared; rst mid-packet aborts immediately, no done/err pulse.
- start sampled at edge T: CALC occupies T+1..T+N, CHECK T+N+1, stage_start (or err) high in cycle T+N+2. Illegal N: CHECK at T+1, err in T+2.
- stage_done sampled at edge D → next stage_start (or source_start) in cycle D+1; no back-to-back overlap.
- source_done at edge S → pkt_done high in cycle S+1 with busy low; a start in cycle S+1 is accepted.
- All outputs registered; no combinational input-to-output path.

## Test plan
- dftpts=1200, N=5, nf=4,5,5,3,4, start at T → stage_start at T+7; stages give (nf,stride,span)=(4,300,1200),(5,60,300),(5,12,60),(3,4,12),(4,1,4); last_stage only on idx 4; source_start one cycle after 5th stage_done; pkt_done one cycle after source_done.
- dftpts=1199, same factors → err pulse at T+7, err_code=1, no stage_start, busy low after.
- nf=4,5,6,3,4 (N=5) → err_code=2; N=0 → err at T+2, err_code=3; N=6 all 5s (15625 overflow) → err_code=1.
- N=1, dftpts=5, nf0=5 → single stage (5,1,5), last_stage=1, then source phase.
- Start during STAGE_WAIT ignored; stage_done in SRC_WAIT ignored; rst asserted in STAGE_WAIT → next cycle all outputs 0, IDLE, subsequent start runs normally.

Source files
------------

// File: rtl/mrd_stage_seq.sv
`default_nettype none
//==============================================================================
// Module      : mrd_stage_seq
// Description : Mixed-radix DFT stage sequencer. Builds the per-stage
//               stride/span table one factor per cycle, validates the packet
//               configuration, then walks the radix stages and the source
//               (read-out) phase through start/done handshakes.
// Revision    : 1.0 - initial release
//==============================================================================
module mrd_stage_seq #(
    parameter int wPTS = 12,
    parameter int MAXF = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [wPTS-1:0]       dftpts,
    input  logic [2:0]            num_factors,
    input  logic [MAXF*3-1:0]     nf,
    input  logic                  stage_done,
    input  logic                  source_done,
    output logic                  busy,
    output logic                  stage_start,
    output logic [2:0]            stage_idx,
    output logic [2:0]            stage_nf,
    output logic [wPTS-1:0]       stage_stride,
    output logic [wPTS-1:0]       stage_span,
    output logic                  last_stage,
    output logic                  source_start,
    output logic                  pkt_done,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int          c_PW         = (wPTS + 4 > 16) ? wPTS + 4 : 16;
    localparam logic [2:0]  c_MAXF       = 3'(MAXF);
    localparam logic [c_PW-1:0] c_PTS_MAX = {{(c_PW-wPTS){1'b0}}, {wPTS{1'b1}}};

    localparam logic [2:0]  c_IDLE       = 3'd0;
    localparam logic [2:0]  c_CALC       = 3'd1;
    localparam logic [2:0]  c_CHECK      = 3'd2;
    localparam logic [2:0]  c_STAGE_GO   = 3'd3;
    localparam logic [2:0]  c_STAGE_WAIT = 3'd4;
    localparam logic [2:0]  c_SRC_GO     = 3'd5;
    localparam logic [2:0]  c_SRC_WAIT   = 3'd6;
    localparam logic [2:0]  c_ERR        = 3'd7;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic [wPTS-1:0]   r_dftpts;
    logic [2:0]        r_num;
    logic [2:0]        r_nf [MAXF];
    logic [wPTS-1:0]   r_stride [MAXF];
    logic [wPTS-1:0]   r_span [MAXF];
    logic [c_PW-1:0]   r_acc;
    logic              r_ovf;
    logic [2:0]        r_j;
    logic [2:0]        r_k;

    logic [2:0]        w_k_load;
    logic [c_PW-1:0]   w_prod;
    logic              w_n_legal_in;
    logic              w_n_legal;
    logic              w_fac_bad;
    logic [1:0]        w_err_code;

    assign w_n_legal_in = (num_factors != 3'd0) && (num_factors <= c_MAXF);
    assign w_n_legal    = (r_num != 3'd0) && (r_num <= c_MAXF);
    assign w_prod       = r_acc * {{(c_PW-3){1'b0}}, r_nf[r_j]};

    // Only the first N factors matter; the rest are don't-care
    always_comb begin
        w_fac_bad = 1'b0;
        for (int i = 0; i < MAXF; i++) begin
            if ((3'(i) < r_num) && ((r_nf[i] < 3'd2) || (r_nf[i] > 3'd5))) begin
                w_fac_bad = 1'b1;
            end
        end
    end

    always_comb begin
        if (!w_n_legal) begin
            w_err_code = 2'd3;
        end else if (w_fac_bad) begin
            w_err_code = 2'd2;
        end else if (r_ovf || (r_acc != {{(c_PW-wPTS){1'b0}}, r_dftpts})) begin
            w_err_code = 2'd1;
        end else begin
            w_err_code = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_load    = 3'd0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = w_n_legal_in ? c_CALC : c_CHECK;
                end
            end
            c_CALC: begin
                if (r_j == 3'd0) begin
                    w_state_nxt = c_CHECK;
                end
            end
            c_CHECK: begin
                w_state_nxt = (w_err_code != 2'd0) ? c_ERR : c_STAGE_GO;
            end
            c_STAGE_GO: begin
                w_state_nxt = c_STAGE_WAIT;
            end
            c_STAGE_WAIT: begin
                if (stage_done) begin
                    if (r_k == r_num - 3'd1) begin
                        w_state_nxt = c_SRC_GO;
                    end else begin
                        w_state_nxt = c_STAGE_GO;
                        w_k_load    = r_k + 3'd1;
                    end
                end
            end
            c_SRC_GO: begin
                w_state_nxt = c_SRC_WAIT;
            end
            c_SRC_WAIT: begin
                if (source_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_ERR: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Outputs are registered off the next state so every pulse lines up with
    // the state it announces.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dftpts     <= '0;
            r_num        <= '0;
            r_acc        <= '0;
            r_ovf        <= 1'b0;
            r_j          <= '0;
            r_k          <= '0;
            for (int i = 0; i < MAXF; i++) begin
                r_nf[i]     <= '0;
                r_stride[i] <= '0;
                r_span[i]   <= '0;
            end
            busy         <= 1'b0;
            stage_start  <= 1'b0;
            stage_idx    <= '0;
            stage_nf     <= '0;
            stage_stride <= '0;
            stage_span   <= '0;
            last_stage   <= 1'b0;
            source_start <= 1'b0;
            pkt_done     <= 1'b0;
            err          <= 1'b0;
            err_code     <= '0;
        end else begin
            busy         <= (w_state_nxt != c_IDLE);
            stage_start  <= 1'b0;
            source_start <= 1'b0;
            pkt_done     <= 1'b0;
            err          <= 1'b0;

            if ((r_state == c_IDLE) && start) begin
                r_dftpts <= dftpts;
                r_num    <= num_factors;
                for (int i = 0; i < MAXF; i++) begin
                    r_nf[i] <= nf[i*3 +: 3];
                end
                err_code <= 2'd0;
                r_acc    <= {{(c_PW-1){1'b0}}, 1'b1};
                r_ovf    <= 1'b0;
                r_j      <= num_factors - 3'd1;
            end

            if (r_state == c_CALC) begin
                r_stride[r_j] <= r_acc[wPTS-1:0];
                r_span[r_j]   <= w_prod[wPTS-1:0];
                r_acc         <= w_prod;
                if (w_prod > c_PTS_MAX) begin
                    r_ovf <= 1'b1;
                end
                r_j <= r_j - 3'd1;
            end

            if ((r_state == c_CHECK) && (w_state_nxt == c_ERR)) begin
                err      <= 1'b1;
                err_code <= w_err_code;
            end

            if (w_state_nxt == c_STAGE_GO) begin
                r_k          <= w_k_load;
                stage_start  <= 1'b1;
                stage_idx    <= w_k_load;
                stage_nf     <= r_nf[w_k_load];
                stage_stride <= r_stride[w_k_load];
                stage_span   <= r_span[w_k_load];
                last_stage   <= (w_k_load == r_num - 3'd1);
            end

            if ((r_state == c_STAGE_WAIT) && (w_state_nxt == c_SRC_GO)) begin
                source_start <= 1'b1;
            end

            if ((r_state == c_SRC_WAIT) && (w_state_nxt == c_IDLE)) begin
                pkt_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mrd_stage_seq.sv
`default_nettype none
//==============================================================================
// Module      : tb_mrd_stage_seq
// Description : Directed self-checking bench for mrd_stage_seq.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mrd_stage_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [11:0] dftpts = '0;
    logic [2:0]  num_factors = '0;
    logic [17:0] nf = '0;
    logic        stage_done = 1'b0;
    logic        source_done = 1'b0;
    logic        busy, stage_start, last_stage, source_start, pkt_done, err;
    logic [2:0]  stage_idx, stage_nf;
    logic [11:0] stage_stride, stage_span;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;

    mrd_stage_seq #(.wPTS(12), .MAXF(6)) dut (
        .clk(clk), .rst(rst), .start(start), .dftpts(dftpts),
        .num_factors(num_factors), .nf(nf), .stage_done(stage_done),
        .source_done(source_done), .busy(busy), .stage_start(stage_start),
        .stage_idx(stage_idx), .stage_nf(stage_nf), .stage_stride(stage_stride),
        .stage_span(stage_span), .last_stage(last_stage),
        .source_start(source_start), .pkt_done(pkt_done), .err(err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] pk(input logic [2:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic do_start(input logic [11:0] d, input logic [2:0] n, input logic [17:0] f);
        dftpts = d;
        num_factors = n;
        nf = f;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stage_done();
        stage_done = 1'b1;
        tick();
        stage_done = 1'b0;
    endtask

    task automatic pulse_source_done();
        source_done = 1'b1;
        tick();
        source_done = 1'b0;
    endtask

    // which: 0 stage_start, 1 source_start, 2 pkt_done, 3 err; cyc=-1 on timeout
    task automatic wait_sig(input int which, input int max, output int cyc);
        logic s;
        cyc = 0;
        forever begin
            case (which)
                0: s = stage_start;
                1: s = source_start;
                2: s = pkt_done;
                default: s = err;
            endcase
            if (s) break;
            if (cyc >= max) begin
                cyc = -1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic check_stage(input string tag, input int idx, input int fn,
                               input int st, input int sp, input int lst);
        check({tag, "_start"}, 32'(stage_start), 1);
        check({tag, "_idx"}, 32'(stage_idx), 32'(idx));
        check({tag, "_nf"}, 32'(stage_nf), 32'(fn));
        check({tag, "_stride"}, 32'(stage_stride), 32'(st));
        check({tag, "_span"}, 32'(stage_span), 32'(sp));
        check({tag, "_last"}, 32'(last_stage), 32'(lst));
    endtask

    int cyc;
    int exp_nf [5] = '{4, 5, 5, 3, 4};
    int exp_st [5] = '{300, 60, 12, 4, 1};
    int exp_sp [5] = '{1200, 300, 60, 12, 4};

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_stage_start", 32'(stage_start), 0);
        check("rst_stride", 32'(stage_stride), 0);
        check("rst_err_code", 32'(err_code), 0);

        // Nominal 1200-point packet
        do_start(12'd1200, 3'd5, pk(4, 5, 5, 3, 4, 0));
        check("t1_busy", 32'(busy), 1);
        wait_sig(0, 20, cyc);
        check("t1_first_lat", 32'(cyc), 6);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                wait_sig(0, 0, cyc);
                check("t1_next_lat", 32'(cyc), 0);
            end
            check_stage($sformatf("t1_s%0d", k), k, exp_nf[k], exp_st[k], exp_sp[k], (k == 4) ? 1 : 0);
            tick();
            check("t1_pulse_one", 32'(stage_start), 0);
            tick();
            pulse_stage_done();
        end
        wait_sig(1, 0, cyc);
        check("t1_src_lat", 32'(cyc), 0);
        tick();
        pulse_stage_done();
        check("t1_ign_stage_done", 32'(stage_start), 0);
        check("t1_src_busy", 32'(busy), 1);
        check("t1_hold_idx", 32'(stage_idx), 4);
        pulse_source_done();
        check("t1_pkt_done", 32'(pkt_done), 1);
        check("t1_busy_low", 32'(busy), 0);

        // Start accepted in the pkt_done cycle; product mismatch
        do_start(12'd1199, 3'd5, pk(4, 5, 5, 3, 4, 0));
        wait_sig(3, 20, cyc);
        check("t2_err_lat", 32'(cyc), 6);
        check("t2_code", 32'(err_code), 1);
        check("t2_no_stage", 32'(stage_start), 0);
        tick();
        check("t2_busy", 32'(busy), 0);
        check("t2_err_pulse", 32'(err), 0);
        tick();
        check("t2_code_held", 32'(err_code), 1);

        // Illegal factor
        do_start(12'd1440, 3'd5, pk(4, 5, 6, 3, 4, 0));
        wait_sig(3, 20, cyc);
        check("t3_err_lat", 32'(cyc), 6);
        check("t3_code", 32'(err_code), 2);
        tick();

        // Illegal N
        do_start(12'd16, 3'd0, pk(4, 4, 0, 0, 0, 0));
        wait_sig(3, 20, cyc);
        check("t4_err_lat", 32'(cyc), 1);
        check("t4_code", 32'(err_code), 3);
        tick();

        // 5^6 overflows 12 bits
        do_start(12'd0, 3'd6, pk(5, 5, 5, 5, 5, 5));
        wait_sig(3, 20, cyc);
        check("t5_err_lat", 32'(cyc), 7);
        check("t5_code", 32'(err_code), 1);
        tick();

        // Single-stage packet
        do_start(12'd5, 3'd1, pk(5, 7, 7, 7, 7, 7));
        check("t6_code_clr", 32'(err_code), 0);
        wait_sig(0, 20, cyc);
        check("t6_lat", 32'(cyc), 2);
        check_stage("t6", 0, 5, 1, 5, 1);
        tick();
        pulse_stage_done();
        check("t6_src", 32'(source_start), 1);
        tick();
        pulse_source_done();
        check("t6_pkt_done", 32'(pkt_done), 1);

        // Start ignored in STAGE_WAIT, then abort by reset
        do_start(12'd1200, 3'd5, pk(4, 5, 5, 3, 4, 0));
        wait_sig(0, 20, cyc);
        check("t7_lat", 32'(cyc), 6);
        tick();
        do_start(12'd16, 3'd0, '0);
        tick();
        tick();
        check("t7_no_err", 32'(err), 0);
        check("t7_busy", 32'(busy), 1);
        check("t7_idx", 32'(stage_idx), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_rst_busy", 32'(busy), 0);
        check("t7_rst_stride", 32'(stage_stride), 0);
        check("t7_rst_span", 32'(stage_span), 0);
        check("t7_rst_nf", 32'(stage_nf), 0);
        tick();
        check("t7_no_pkt_done", 32'(pkt_done), 0);
        do_start(12'd4, 3'd1, pk(4, 0, 0, 0, 0, 0));
        wait_sig(0, 20, cyc);
        check("t7_restart_lat", 32'(cyc), 2);
        check_stage("t7r", 0, 4, 1, 4, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
